reg_serializer: RTL and testbench

Parallel-in, serial-out word transmitter: the read-side counterpart of the parallel-load register. It captures a WIDTH-bit word on a store strobe and streams it out one bit per accepted cycle under a valid/ready handshake. It sits between the register/datapath layer and any bit-serial consumer, such as an output port, a serial link or a bit-serial ALU. It signals completion with a one-cycle `done` pulse.

---
 rtl/reg_serializer.sv | 87 ++++++++
 tb/tb_reg_serializer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_serializer.sv
// Parallel-in, serial-out word transmitter with a valid/ready output handshake and a done pulse.
// Bit order is LSB-first by default; define REG_SERIALIZER_MSB_FIRST_EN for MSB-first.
module reg_serializer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             st,
   input  logic [WIDTH-1:0] d,
   output logic             sout,
   output logic             sval,
   input  logic             srdy,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] sh_reg, sh_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             done_reg, done_next;
   logic [WIDTH-1:0] sh_shifted;
   logic             head_bit;

`ifdef REG_SERIALIZER_MSB_FIRST_EN
   assign head_bit   = sh_reg[WIDTH-1];
   assign sh_shifted = {sh_reg[WIDTH-2:0], 1'b0};
`else
   assign head_bit   = sh_reg[0];
   assign sh_shifted = {1'b0, sh_reg[WIDTH-1:1]};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         sh_reg    <= '0;
         cnt_reg   <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         sh_reg    <= sh_next;
         cnt_reg   <= cnt_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      sh_next    = sh_reg;
      cnt_next   = cnt_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (st) begin
               sh_next    = d;
               cnt_next   = CW'(WIDTH);
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            // Stalled cycles hold everything so sout stays stable for the consumer.
            if (srdy) begin
               sh_next  = sh_shifted;
               cnt_next = cnt_reg - CW'(1);
               if (cnt_reg == CW'(1)) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs depend only on registered state; srdy never reaches them combinationally.
   assign busy = (state_reg == SHIFT);
   assign sval = busy;
   assign sout = busy & head_bit;
   assign done = done_reg;

endmodule

// File: tb/tb_reg_serializer.sv
// Self-checking bench for reg_serializer: directed scenarios followed by random traffic,
// all checked against a queue-of-pending-bits reference model.
module tb_reg_serializer;

   localparam int W = 16;

   logic         clk  = 1'b0;
   logic         rst  = 1'b1;
   logic         st   = 1'b0;
   logic         srdy = 1'b0;
   logic [W-1:0] d    = '0;
   logic         sout, sval, busy, done;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   bit mq[$];        // bits still to be transferred for the word in flight
   bit done_exp = 1'b0;
   bit rx[$];        // bits actually handed to the consumer

   always #5 clk = ~clk;

   reg_serializer #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .st   (st),
      .d    (d),
      .sout (sout),
      .sval (sval),
      .srdy (srdy),
      .busy (busy),
      .done (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour at one clock edge, using the inputs present before the edge.
   task automatic model_edge();
      bit was_busy;
      was_busy = (mq.size() != 0);
      done_exp = 1'b0;
      if (rst) begin
         mq.delete();
      end else if (was_busy) begin
         if (srdy) begin
            void'(mq.pop_front());
            if (mq.size() == 0) done_exp = 1'b1;
         end
      end else if (st) begin
`ifdef REG_SERIALIZER_MSB_FIRST_EN
         for (int i = W - 1; i >= 0; i--) mq.push_back(d[i]);
`else
         for (int i = 0; i < W; i++) mq.push_back(d[i]);
`endif
      end
   endtask

   task automatic tick();
      logic pre_xfer, pre_bit;
      pre_xfer = sval & srdy & ~rst;
      pre_bit  = sout;
      @(posedge clk);
      #1;
      if (pre_xfer === 1'b1) rx.push_back(pre_bit);
      model_edge();
      if (done === 1'b1) done_seen++;
      check("sval", {31'd0, sval}, {31'd0, mq.size() != 0});
      check("busy", {31'd0, busy}, {31'd0, mq.size() != 0});
      check("sout", {31'd0, sout}, {31'd0, (mq.size() != 0) ? mq[0] : 1'b0});
      check("done", {31'd0, done}, {31'd0, done_exp});
   endtask

   function automatic logic [W-1:0] rx_word();
      logic [W-1:0] w;
      w = '0;
      for (int i = 0; i < rx.size() && i < W; i++) begin
`ifdef REG_SERIALIZER_MSB_FIRST_EN
         w[W-1-i] = rx[i];
`else
         w[i] = rx[i];
`endif
      end
      return w;
   endfunction

   task automatic wait_done(input string tag, input int max_cycles);
      int n;
      n = 0;
      while (done !== 1'b1 && n < max_cycles) begin
         tick();
         n++;
      end
      check({tag, "_done_timeout"}, {31'd0, done}, 32'd1);
   endtask

   task automatic load(input logic [W-1:0] word);
      st = 1'b1;
      d  = word;
      tick();
      st = 1'b0;
      d  = W'($urandom);
   endtask

   initial begin
      int n;
      logic [W-1:0] exp_b2b;

      // Reset, then idle
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick();

      // Basic transfer with srdy held high
      rx.delete();
      done_seen = 0;
      srdy = 1'b1;
      load(16'hA5C3);
      wait_done("basic", 40);
      check("basic_nbits", rx.size(), 32'd16);
      check("basic_word", {16'd0, rx_word()}, 32'h0000A5C3);
      tick();
      check("basic_done_once", done_seen, 32'd1);

      // Back-pressure: srdy pattern 1,0,0,1 repeating
      rx.delete();
      load(16'hA5C3);
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         srdy = (n % 4 == 0) || (n % 4 == 3);
         tick();
         n++;
      end
      check("bp_done_timeout", {31'd0, done}, 32'd1);
      check("bp_cycles", n, 32'd32);
      check("bp_word", {16'd0, rx_word()}, 32'h0000A5C3);
      srdy = 1'b1;
      tick();

      // Store strobe during a transfer is ignored
      rx.delete();
      load(16'hA5C3);
      for (int i = 0; i < 5; i++) tick();
      st = 1'b1;
      d  = 16'hFFFF;
      tick();
      st = 1'b0;
      wait_done("ign", 40);
      check("ign_nbits", rx.size(), 32'd16);
      check("ign_word", {16'd0, rx_word()}, 32'h0000A5C3);
      tick();
      check("ign_no_restart", {31'd0, busy}, 32'd0);

      // Back-to-back store in the done cycle, then reset abort at bit 8
      load(16'hA5C3);
      wait_done("b2b_first", 40);
      rx.delete();
      load(16'h0001);
      check("b2b_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 8; i++) tick();
`ifdef REG_SERIALIZER_MSB_FIRST_EN
      exp_b2b = 16'h0000;
`else
      exp_b2b = 16'h0001;
`endif
      check("b2b_nbits", rx.size(), 32'd8);
      check("b2b_bits", {16'd0, rx_word()}, {16'd0, exp_b2b});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_sval", {31'd0, sval}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      done_seen = 0;
      for (int i = 0; i < 20; i++) tick();
      check("abort_no_done", done_seen, 32'd0);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         st   = ($urandom_range(0, 3) == 0);
         d    = W'($urandom);
         srdy = ($urandom_range(0, 2) != 0);
         rst  = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;
      st  = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
